dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered-output data memory among NUM_CORES cores.
// Latency: write ack starts 2 edges after the sampling edge, read ack 2+RD_LATENCY edges.
// Backpressure: requests are level-held until ack; one transaction at a time, losers simply wait.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req/we/addr/wdata   per-core request bundle, core i at slice i
//   gnt/ack             one-hot owner of the current transaction / one-cycle completion pulse
//   rdata               read data, valid in the ack cycle and held until the next read completes
//   busy                high whenever the sequencer is not idle
//   mem_*               single-port memory interface (q returns RD_LATENCY clocks after sampling)
module dmem_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CORES-1:0]      req,
  input  logic [NUM_CORES-1:0]      we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*DATA_W-1:0] wdata,
  output logic [NUM_CORES-1:0]      gnt,
  output logic [NUM_CORES-1:0]      ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_wren,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [SEL_W-1:0]   last_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               sel_found;
  logic [SEL_W-1:0]   sel_idx;
  logic [SEL_W-1:0]   cand;

  // Rotating search starting just after the last served core, wrapping at
  // NUM_CORES-1 (not at a power of two) so odd core counts rotate correctly.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = last_q;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = (cand == SEL_W'(NUM_CORES - 1)) ? '0 : cand + 1'b1;
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. mem_wren is only ever set during ACCESS, so it doubles
  // as the latched write/read flag of the transaction in that state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sel_found) state_d = ACCESS;
      ACCESS:  state_d = mem_wren ? DONE : WAIT;
      WAIT:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt       <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      cnt_q     <= '0;
      last_q    <= SEL_W'(NUM_CORES - 1);
    end else begin
      busy <= (state_d != IDLE);
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            mem_addr  <= addr[int'(sel_idx)*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[int'(sel_idx)*DATA_W +: DATA_W];
            mem_wren  <= we[sel_idx];
            gnt       <= NUM_CORES'(1) << sel_idx;
            last_q    <= sel_idx;
          end
        end
        ACCESS: begin
          // The memory samples address/data/wren at this edge.
          mem_wren <= 1'b0;
          if (mem_wren) begin
            ack <= gnt;
          end else begin
            cnt_q <= CNT_W'(RD_LATENCY - 1);
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rdata <= mem_rdata;
            ack   <= gnt;
          end
        end
        DONE: begin
          ack <= '0;
          gnt <= '0;
        end
        default: begin
          ack <= '0;
          gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: two instances (RD_LATENCY 1 and 3) with behavioural memories.
// Expected transactions are queued at issue time; a negedge monitor pops and checks on every ack.
// Requesters hold req until ack and drop it at the following edge.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: RD_LATENCY = 1
  logic [3:0]  req_a = '0, we_a = '0, gnt_a, ack_a;
  logic [63:0] addr_a = '0, wdata_a = '0;
  logic [15:0] rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        busy_a, mem_wren_a;

  // Instance B: RD_LATENCY = 3
  logic [3:0]  req_b = '0, we_b = '0, gnt_b, ack_b;
  logic [63:0] addr_b = '0, wdata_b = '0;
  logic [15:0] rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic        busy_b, mem_wren_b;

  dmem_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
    .gnt(gnt_a), .ack(ack_a), .rdata(rdata_a), .busy(busy_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_wren(mem_wren_a), .mem_rdata(mem_rdata_a)
  );

  dmem_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16), .RD_LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
    .gnt(gnt_b), .ack(ack_b), .rdata(rdata_b), .busy(busy_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_wren(mem_wren_b), .mem_rdata(mem_rdata_b)
  );

  // Memory models: registered read, plus extra pipeline stages for instance B.
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic [15:0] qa, pb0, pb1, pb2;

  always @(posedge clk) begin
    if (mem_wren_a) mem_a[mem_addr_a[7:0]] <= mem_wdata_a;
    qa <= mem_a[mem_addr_a[7:0]];
    if (mem_wren_b) mem_b[mem_addr_b[7:0]] <= mem_wdata_b;
    pb0 <= mem_b[mem_addr_b[7:0]];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign mem_rdata_a = qa;
  assign mem_rdata_b = pb2;

  typedef struct {
    int          core;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    int          lat;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];

  logic [3:0]  pg [2];
  logic [3:0]  pa [2];
  int          gcyc [2];
  int          wren_n [2];
  logic [15:0] gaddr [2];
  logic [15:0] gwd [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act === req_v) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req_v, cyc);
  endtask

  function automatic void push(input int id, input int core, input bit wr,
                               input logic [15:0] ad, input logic [15:0] d, input int lat);
    exp_t e;
    e.core = core; e.wr = wr; e.addr = ad; e.data = d; e.lat = lat;
    if (id == 0) exp_a.push_back(e);
    else exp_b.push_back(e);
  endfunction

  task automatic mon_step(input int id, input logic [3:0] g, input logic [3:0] a,
                          input logic [15:0] ma, input logic [15:0] mwd,
                          input logic [15:0] rd, input logic mw);
    exp_t e;
    bit   have;
    if (g != 0 && pg[id] == 0) begin
      gcyc[id] = cyc; gaddr[id] = ma; gwd[id] = mwd; wren_n[id] = 0;
    end
    if (g != 0 || a != 0 || mw) begin
      chk("gnt_onehot", 32'($onehot0(g)), 32'd1);
      chk("ack_onehot", 32'($onehot0(a)), 32'd1);
      chk("ack_single_cycle", 32'(a & pa[id]), 32'd0);
      chk("wren_only_in_access", 32'(mw && !(g != 0 && pg[id] == 0)), 32'd0);
    end
    if (mw) wren_n[id]++;
    if (a != 0) begin
      have = (id == 0) ? (exp_a.size() != 0) : (exp_b.size() != 0);
      if (!have) begin
        chk("unexpected_ack", 32'(a), 32'd0);
      end else begin
        if (id == 0) e = exp_a.pop_front();
        else e = exp_b.pop_front();
        chk("ack_core", 32'(a), 32'(4'd1 << e.core));
        chk("gnt_at_ack", 32'(g), 32'(4'd1 << e.core));
        chk("latency", 32'(cyc - gcyc[id] + 1), 32'(e.lat));
        chk("mem_addr", 32'(gaddr[id]), 32'(e.addr));
        chk("wren_cycles", 32'(wren_n[id]), 32'(e.wr));
        if (e.wr) chk("mem_wdata", 32'(gwd[id]), 32'(e.data));
        else chk("rdata", 32'(rd), 32'(e.data));
      end
    end
    pg[id] = g;
    pa[id] = a;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        pg[i] = '0; pa[i] = '0; wren_n[i] = 0;
      end
    end else begin
      mon_step(0, gnt_a, ack_a, mem_addr_a, mem_wdata_a, rdata_a, mem_wren_a);
      mon_step(1, gnt_b, ack_b, mem_addr_b, mem_wdata_b, rdata_b, mem_wren_b);
    end
  end

  // n transactions from core c on instance A, one idle cycle between them.
  task automatic requester(input int c, input int n, input bit wr,
                           input logic [15:0] ad0, input logic [15:0] d0);
    int t;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      we_a[c] = wr;
      addr_a[c*16 +: 16]  = ad0 + 16'(k);
      wdata_a[c*16 +: 16] = d0 + 16'(k);
      req_a[c] = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!ack_a[c] && t < 100);
      chk("ack_seen_a", 32'(ack_a[c]), 32'd1);
      @(posedge clk); #1;
      req_a[c] = 1'b0;
    end
  endtask

  task automatic requester_b(input int c, input bit wr, input logic [15:0] ad, input logic [15:0] d);
    int t;
    @(posedge clk); #1;
    we_b[c] = wr;
    addr_b[c*16 +: 16]  = ad;
    wdata_b[c*16 +: 16] = d;
    req_b[c] = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!ack_b[c] && t < 100);
    chk("ack_seen_b", 32'(ack_b[c]), 32'd1);
    @(posedge clk); #1;
    req_b[c] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    // Reset held with random inputs on instance A
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req_a = 4'($urandom); we_a = 4'($urandom);
      addr_a = {$urandom, $urandom}; wdata_a = {$urandom, $urandom};
    end
    @(negedge clk);
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_ack", 32'(ack_a), 32'd0);
    chk("rst_rdata", 32'(rdata_a), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_a), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata_a), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    req_a = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy_a), 32'd0);
      chk("idle_wren", 32'(mem_wren_a), 32'd0);
      chk("idle_gnt", 32'(gnt_a), 32'd0);
    end

    // Core 2 write
    push(0, 2, 1'b1, 16'h0040, 16'h1234, 2);
    requester(2, 1, 1'b1, 16'h0040, 16'h1234);

    // Last served core 2; cores 1 and 3 request together -> 3 then 1
    push(0, 3, 1'b1, 16'h0050, 16'h3333, 2);
    push(0, 1, 1'b1, 16'h0060, 16'h1111, 2);
    fork
      requester(1, 1, 1'b1, 16'h0060, 16'h1111);
      requester(3, 1, 1'b1, 16'h0050, 16'h3333);
    join

    // Core 1 read of the value core 2 wrote, RD_LATENCY = 1
    push(0, 1, 1'b0, 16'h0040, 16'h1234, 3);
    requester(1, 1, 1'b0, 16'h0040, 16'h0000);
    repeat (3) @(negedge clk);
    chk("rdata_held", 32'(rdata_a), 32'h1234);

    // Core 3 read leaves the pointer on core 3
    push(0, 3, 1'b0, 16'h0050, 16'h3333, 3);
    requester(3, 1, 1'b0, 16'h0050, 16'h0000);

    // All cores requesting continuously: grant order 0,1,2,3,0,1,2,3
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 4; c++)
        push(0, c, 1'b1, 16'h0080 + 16'(c*4 + k), 16'hA000 + 16'(c*16 + k), 2);
    fork
      requester(0, 2, 1'b1, 16'h0080, 16'hA000);
      requester(1, 2, 1'b1, 16'h0084, 16'hA010);
      requester(2, 2, 1'b1, 16'h0088, 16'hA020);
      requester(3, 2, 1'b1, 16'h008C, 16'hA030);
    join

    // Instance B: write then read back with RD_LATENCY = 3
    push(1, 0, 1'b1, 16'h0040, 16'h1234, 2);
    requester_b(0, 1'b1, 16'h0040, 16'h1234);
    push(1, 1, 1'b0, 16'h0040, 16'h1234, 5);
    requester_b(1, 1'b0, 16'h0040, 16'h0000);
    repeat (2) @(negedge clk);
    chk("rdata_held_b", 32'(rdata_b), 32'h1234);

    // Reset during WAIT of a core 0 read; core 0 keeps req high
    push(0, 0, 1'b0, 16'h0080, 16'hA000, 3);
    @(posedge clk); #1;
    we_a[0] = 1'b0; addr_a[15:0] = 16'h0080; req_a[0] = 1'b1;
    t = 0;
    while (!gnt_a[0] && t < 50) begin @(negedge clk); t++; end
    chk("rst_test_grant", 32'(gnt_a), 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_ack", 32'(ack_a), 32'd0);
    chk("midrst_rdata", 32'(rdata_a), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!ack_a[0] && t < 100);
    chk("regrant_ack", 32'(ack_a), 32'd1);
    @(posedge clk); #1;
    req_a[0] = 1'b0;

    repeat (5) @(negedge clk);
    chk("sb_a_drained", 32'(exp_a.size()), 32'd0);
    chk("sb_b_drained", 32'(exp_b.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
